// File: rtl/core_pkg.sv
// Shared types and constants for the core pipeline stages.
package core_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FIN  = 2'd2
    } mem_state_t;

    typedef enum logic {
        LOAD  = 1'b0,
        STORE = 1'b1
    } mem_op_t;

    localparam int MEM_TIMEOUT_DEF = 255;

endpackage

// File: rtl/mem_access_unit.sv
// Memory-access stage: turns one load/store request into a req/ack memory
// transaction and reports completion as finish/error pulses.
module mem_access_unit
    import core_pkg::*;
#(
    parameter int ADDR_W  = 17,
    parameter int TIMEOUT = MEM_TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              ld_valid,
    input  logic              st_valid,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              load_finish,
    output logic              store_finish,
    output logic              acc_err,
    output logic              busy,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
);

    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    mem_state_t        state_q;
    mem_op_t           op_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [31:0]       rdata_q;
    logic              load_finish_q;
    logic              store_finish_q;
    logic              acc_err_q;
    logic              busy_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic              req_bad;

    // Misaligned, beyond the word array, or both request types at once.
    always_comb begin
        req_bad = (addr[1:0] != 2'b00)
               || ((addr >> (ADDR_W + 2)) != 32'd0)
               || (ld_valid && st_valid);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q        <= IDLE;
            op_q           <= LOAD;
            cnt_q          <= '0;
            rdata_q        <= '0;
            load_finish_q  <= 1'b0;
            store_finish_q <= 1'b0;
            acc_err_q      <= 1'b0;
            busy_q         <= 1'b0;
            mem_req_q      <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
        end else begin
            load_finish_q  <= 1'b0;
            store_finish_q <= 1'b0;
            acc_err_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ld_valid || st_valid) begin
                        busy_q      <= 1'b1;
                        op_q        <= ld_valid ? LOAD : STORE;
                        mem_we_q    <= st_valid && !ld_valid;
                        mem_addr_q  <= addr[ADDR_W+1:2];
                        mem_wdata_q <= wdata;
                        cnt_q       <= '0;
                        if (req_bad) begin
                            state_q        <= FIN;
                            load_finish_q  <= ld_valid;
                            store_finish_q <= st_valid;
                            acc_err_q      <= 1'b1;
                            if (ld_valid) begin
                                rdata_q <= '0;
                            end
                        end else begin
                            state_q   <= REQ;
                            mem_req_q <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        state_q   <= FIN;
                        if (op_q == LOAD) begin
                            rdata_q       <= mem_rdata;
                            load_finish_q <= 1'b1;
                        end else begin
                            store_finish_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        // Abort so a dead memory cannot stall the core.
                        if (cnt_q == TO_LAST) begin
                            mem_req_q <= 1'b0;
                            state_q   <= FIN;
                            acc_err_q <= 1'b1;
                            if (op_q == LOAD) begin
                                rdata_q       <= '0;
                                load_finish_q <= 1'b1;
                            end else begin
                                store_finish_q <= 1'b1;
                            end
                        end
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rdata        = rdata_q;
    assign load_finish  = load_finish_q;
    assign store_finish = store_finish_q;
    assign acc_err      = acc_err_q;
    assign busy         = busy_q;
    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: default-timeout instance plus a TIMEOUT=4 instance.
module tb_mem_access_unit;

    localparam int ADDR_W = 17;

    logic clk = 1'b0;
    logic rstn;

    logic              ld_valid, st_valid, mem_ack;
    logic [31:0]       addr, wdata, mem_rdata;
    logic [31:0]       rdata, mem_wdata;
    logic              load_finish, store_finish, acc_err, busy, mem_req, mem_we;
    logic [ADDR_W-1:0] mem_addr;

    logic              ld_valid2, st_valid2, mem_ack2;
    logic [31:0]       addr2, wdata2, mem_rdata2;
    logic [31:0]       rdata2, mem_wdata2;
    logic              load_finish2, store_finish2, acc_err2, busy2, mem_req2, mem_we2;
    logic [ADDR_W-1:0] mem_addr2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rstn(rstn),
        .ld_valid(ld_valid), .st_valid(st_valid), .addr(addr), .wdata(wdata),
        .rdata(rdata), .load_finish(load_finish), .store_finish(store_finish),
        .acc_err(acc_err), .busy(busy), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack)
    );

    mem_access_unit #(.ADDR_W(ADDR_W), .TIMEOUT(4)) dut_to (
        .clk(clk), .rstn(rstn),
        .ld_valid(ld_valid2), .st_valid(st_valid2), .addr(addr2), .wdata(wdata2),
        .rdata(rdata2), .load_finish(load_finish2), .store_finish(store_finish2),
        .acc_err(acc_err2), .busy(busy2), .mem_req(mem_req2), .mem_we(mem_we2),
        .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2),
        .mem_ack(mem_ack2)
    );

    task automatic idle_inputs();
        ld_valid = 0; st_valid = 0; mem_ack = 0; addr = 0; wdata = 0; mem_rdata = 0;
        ld_valid2 = 0; st_valid2 = 0; mem_ack2 = 0; addr2 = 0; wdata2 = 0; mem_rdata2 = 0;
    endtask

    task automatic test_reset();
        rstn = 0;
        idle_inputs();
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({load_finish, store_finish, acc_err, busy, mem_req, mem_we} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b required 000000",
                     {load_finish, store_finish, acc_err, busy, mem_req, mem_we});
        end
        n_cmp++;
        if ({rdata, mem_wdata, mem_addr} !== '0) begin
            n_err++;
            $display("FAIL reset_data: rdata %h wdata %h addr %h required all 0",
                     rdata, mem_wdata, mem_addr);
        end
        n_cmp++;
        if ({load_finish2, store_finish2, acc_err2, busy2, mem_req2, mem_we2, rdata2} !== '0) begin
            n_err++;
            $display("FAIL reset_to_inst: got nonzero outputs on TIMEOUT=4 instance");
        end
        rstn = 1;
        @(negedge clk);
    endtask

    task automatic test_load();
        ld_valid = 1; addr = 32'h0000_0010;
        @(negedge clk);                       // C+1
        ld_valid = 0; addr = 0;
        n_cmp++;
        if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 17'd4}) begin
            n_err++;
            $display("FAIL load_req: req %b we %b addr %h required 1 0 00004", mem_req, mem_we, mem_addr);
        end
        @(negedge clk);                       // C+2: ack
        n_cmp++;
        if ({mem_req, load_finish} !== 2'b10) begin
            n_err++;
            $display("FAIL load_wait: req/fin %b required 10", {mem_req, load_finish});
        end
        mem_ack = 1; mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);                       // C+3: finish
        mem_ack = 0; mem_rdata = 0;
        n_cmp++;
        if ({load_finish, store_finish, acc_err, mem_req, busy} !== 5'b10001 || rdata !== 32'hDEAD_BEEF) begin
            n_err++;
            $display("FAIL load_fin: flags %b rdata %h required 10001 deadbeef",
                     {load_finish, store_finish, acc_err, mem_req, busy}, rdata);
        end
        @(negedge clk);
        n_cmp++;
        if ({load_finish, busy} !== 2'b00 || rdata !== 32'hDEAD_BEEF) begin
            n_err++;
            $display("FAIL load_after: fin/busy %b rdata %h required 00 deadbeef", {load_finish, busy}, rdata);
        end
    endtask

    task automatic test_store();
        int busy_n = 0;
        int fin_n = 0;
        st_valid = 1; addr = 32'h0000_0100; wdata = 32'h1234_5678;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            st_valid = 0; addr = 0; wdata = 0; mem_ack = 0;
            if (busy) busy_n++;
            if (store_finish) fin_n++;
            if (i == 1) begin
                n_cmp++;
                if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 17'h40, 32'h1234_5678}) begin
                    n_err++;
                    $display("FAIL store_req: req %b we %b addr %h wdata %h required 1 1 00040 12345678",
                             mem_req, mem_we, mem_addr, mem_wdata);
                end
            end
            if (i == 7) begin
                n_cmp++;
                if ({store_finish, load_finish, acc_err, mem_req} !== 4'b1000) begin
                    n_err++;
                    $display("FAIL store_fin: flags %b required 1000",
                             {store_finish, load_finish, acc_err, mem_req});
                end
            end
            if (i == 6) mem_ack = 1;
        end
        n_cmp++;
        if (fin_n !== 1) begin
            n_err++;
            $display("FAIL store_pulses: got %0d required 1", fin_n);
        end
        n_cmp++;
        if (busy_n !== 7) begin
            n_err++;
            $display("FAIL store_busy: got %0d cycles required 7", busy_n);
        end
    endtask

    task automatic test_misaligned();
        ld_valid = 1; addr = 32'h0000_0003;
        @(negedge clk);
        ld_valid = 0; addr = 0;
        n_cmp++;
        if ({mem_req, load_finish, store_finish, acc_err} !== 4'b0101 || rdata !== 32'd0) begin
            n_err++;
            $display("FAIL misaligned: req/ld/st/err %b rdata %h required 0101 00000000",
                     {mem_req, load_finish, store_finish, acc_err}, rdata);
        end
        @(negedge clk);
        n_cmp++;
        if ({mem_req, load_finish, acc_err, busy} !== 4'b0000) begin
            n_err++;
            $display("FAIL misaligned_after: req/ld/err/busy %b required 0000",
                     {mem_req, load_finish, acc_err, busy});
        end
    endtask

    task automatic test_range();
        // Highest in-range word goes to memory normally.
        ld_valid = 1; addr = 32'h0007_FFFC;
        @(negedge clk);
        ld_valid = 0; addr = 0;
        n_cmp++;
        if ({mem_req, mem_addr} !== {1'b1, 17'h1FFFF}) begin
            n_err++;
            $display("FAIL range_top_req: req %b addr %h required 1 1ffff", mem_req, mem_addr);
        end
        mem_ack = 1; mem_rdata = 32'hA5A5_0001;
        @(negedge clk);
        mem_ack = 0; mem_rdata = 0;
        n_cmp++;
        if ({load_finish, acc_err} !== 2'b10 || rdata !== 32'hA5A5_0001) begin
            n_err++;
            $display("FAIL range_top_fin: fin/err %b rdata %h required 10 a5a50001", {load_finish, acc_err}, rdata);
        end
        @(negedge clk);
        ld_valid = 1; addr = 32'h0008_0000;
        @(negedge clk);
        ld_valid = 0; addr = 0;
        n_cmp++;
        if ({mem_req, load_finish, acc_err} !== 3'b011 || rdata !== 32'd0) begin
            n_err++;
            $display("FAIL range_out: req/fin/err %b rdata %h required 011 00000000",
                     {mem_req, load_finish, acc_err}, rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_conflict();
        // Leave non-zero read data first so the error clear is visible.
        ld_valid = 1; addr = 32'h0000_0020;
        @(negedge clk);
        ld_valid = 0; mem_ack = 1; mem_rdata = 32'h0BAD_F00D;
        @(negedge clk);
        mem_ack = 0; mem_rdata = 0;
        @(negedge clk);
        ld_valid = 1; st_valid = 1; addr = 32'h0000_0020; wdata = 32'h5555_AAAA;
        @(negedge clk);
        ld_valid = 0; st_valid = 0; addr = 0; wdata = 0;
        n_cmp++;
        if ({load_finish, store_finish, acc_err, mem_req} !== 4'b1110 || rdata !== 32'd0) begin
            n_err++;
            $display("FAIL conflict: ld/st/err/req %b rdata %h required 1110 00000000",
                     {load_finish, store_finish, acc_err, mem_req}, rdata);
        end
        @(negedge clk);
        n_cmp++;
        if ({load_finish, store_finish, acc_err, mem_req} !== 4'b0000) begin
            n_err++;
            $display("FAIL conflict_after: flags %b required 0000",
                     {load_finish, store_finish, acc_err, mem_req});
        end
    endtask

    task automatic test_back_to_back();
        ld_valid = 1; addr = 32'h0000_0040;                        // C
        @(negedge clk);                                            // C+1 REQ
        ld_valid = 0; addr = 32'h0000_0080; st_valid = 1;          // ignored while busy
        mem_ack = 1; mem_rdata = 32'h1111_2222;
        @(negedge clk);                                            // C+2 FIN
        st_valid = 0; addr = 0; mem_ack = 0; mem_rdata = 0;
        n_cmp++;
        if ({load_finish, store_finish} !== 2'b10 || rdata !== 32'h1111_2222) begin
            n_err++;
            $display("FAIL b2b_load: ld/st %b rdata %h required 10 11112222", {load_finish, store_finish}, rdata);
        end
        @(negedge clk);                                            // C+3 IDLE
        n_cmp++;
        if ({mem_req, busy} !== 2'b00) begin
            n_err++;
            $display("FAIL b2b_ignored: req/busy %b required 00", {mem_req, busy});
        end
        st_valid = 1; addr = 32'h0000_0044; wdata = 32'hCAFE_0044;
        @(negedge clk);                                            // C+4 REQ
        st_valid = 0; addr = 0; wdata = 0;
        n_cmp++;
        if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 17'h11, 32'hCAFE_0044}) begin
            n_err++;
            $display("FAIL b2b_store_req: req %b we %b addr %h wdata %h required 1 1 00011 cafe0044",
                     mem_req, mem_we, mem_addr, mem_wdata);
        end
        mem_ack = 1;
        @(negedge clk);                                            // C+5 FIN
        mem_ack = 0;
        n_cmp++;
        if ({store_finish, load_finish, acc_err} !== 3'b100 || rdata !== 32'h1111_2222) begin
            n_err++;
            $display("FAIL b2b_store_fin: st/ld/err %b rdata %h required 100 11112222",
                     {store_finish, load_finish, acc_err}, rdata);
        end
        @(negedge clk);                                            // stray ack while idle
        mem_ack = 1; mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        mem_ack = 0; mem_rdata = 0;
        n_cmp++;
        if ({load_finish, store_finish, acc_err, busy, mem_req} !== 5'b0 || rdata !== 32'h1111_2222) begin
            n_err++;
            $display("FAIL stray_ack: flags %b rdata %h required 00000 11112222",
                     {load_finish, store_finish, acc_err, busy, mem_req}, rdata);
        end
    endtask

    task automatic test_timeout();
        int req_n = 0;
        int fin_n = 0;
        ld_valid2 = 1; addr2 = 32'h0000_0008;
        @(negedge clk);
        ld_valid2 = 0; mem_ack2 = 1; mem_rdata2 = 32'hCAFE_F00D;
        @(negedge clk);
        mem_ack2 = 0; mem_rdata2 = 0;
        n_cmp++;
        if (load_finish2 !== 1'b1 || rdata2 !== 32'hCAFE_F00D) begin
            n_err++;
            $display("FAIL to_preload: fin %b rdata %h required 1 cafef00d", load_finish2, rdata2);
        end
        @(negedge clk);
        ld_valid2 = 1; addr2 = 32'h0000_0008;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            ld_valid2 = 0;
            if (mem_req2) req_n++;
            if (load_finish2) fin_n++;
            if (i == 5) begin
                n_cmp++;
                if ({mem_req2, load_finish2, acc_err2} !== 3'b011 || rdata2 !== 32'd0) begin
                    n_err++;
                    $display("FAIL timeout_fin: req/fin/err %b rdata %h required 011 00000000",
                             {mem_req2, load_finish2, acc_err2}, rdata2);
                end
            end
        end
        n_cmp++;
        if (req_n !== 4) begin
            n_err++;
            $display("FAIL timeout_req_len: got %0d cycles required 4", req_n);
        end
        n_cmp++;
        if (fin_n !== 1) begin
            n_err++;
            $display("FAIL timeout_pulses: got %0d required 1", fin_n);
        end
    endtask

    task automatic test_mid_reset();
        int fin_n = 0;
        st_valid = 1; addr = 32'h0000_0200; wdata = 32'h7777_8888;
        @(negedge clk);
        st_valid = 0; addr = 0; wdata = 0;
        n_cmp++;
        if ({mem_req, mem_we} !== 2'b11) begin
            n_err++;
            $display("FAIL midrst_req: req/we %b required 11", {mem_req, mem_we});
        end
        @(negedge clk);
        rstn = 0; mem_ack = 1;
        @(negedge clk);
        rstn = 1; mem_ack = 0;
        n_cmp++;
        if ({mem_req, mem_we, busy, store_finish, mem_addr, mem_wdata} !== '0) begin
            n_err++;
            $display("FAIL midrst_outputs: req %b we %b busy %b fin %b addr %h wdata %h required all 0",
                     mem_req, mem_we, busy, store_finish, mem_addr, mem_wdata);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (store_finish || load_finish || acc_err || mem_req) fin_n++;
        end
        n_cmp++;
        if (fin_n !== 0) begin
            n_err++;
            $display("FAIL midrst_no_finish: got %0d active cycles required 0", fin_n);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_store();
        test_misaligned();
        test_range();
        test_conflict();
        test_back_to_back();
        test_timeout();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
